// File: rtl/mmu_pxr_bridge.sv
// Bus-to-MMU register bridge: decodes PDR/PAR/MMR0-3 I/O-page addresses and turns held bus
// strobes into one-cycle pxr accesses. Define MMU_SUPER_EN to decode the supervisor PDR/PAR group.
module mmu_pxr_bridge (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [21:0] bus_addr,
   input  logic        bus_rd,
   input  logic        bus_wr,
   input  logic        bus_byte,
   input  logic [15:0] bus_data_in,
   output logic [15:0] bus_data_out,
   output logic        bus_ack,
   output logic        bus_decode,
   output logic        pxr_rd,
   output logic        pxr_wr,
   output logic [1:0]  pxr_be,
   output logic [7:0]  pxr_addr,
   output logic [15:0] pxr_data_in,
   input  logic [15:0] pxr_data_out
);

   typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

   state_e      state_q, state_d;
   logic        pxr_rd_q, pxr_rd_d;
   logic        pxr_wr_q, pxr_wr_d;
   logic [1:0]  pxr_be_q, pxr_be_d;
   logic [7:0]  pxr_addr_q, pxr_addr_d;
   logic [15:0] pxr_data_q, pxr_data_d;
   logic [15:0] rdata_q, rdata_d;
   logic        ack_q, ack_d;

   logic        hit_kern, hit_super, hit_user, hit_mmr;
   logic [1:0]  mmr_idx;
   logic [1:0]  mode;
   logic [21:0] word_addr;
   logic [7:0]  map_addr;
   logic [1:0]  map_be;
   logic        strobe;

   assign word_addr = {bus_addr[21:1], 1'b0};
   assign strobe    = bus_rd | bus_wr;

   // Address decode: three 64-byte PDR/PAR groups plus four scattered MMR words.
   always_comb begin
      hit_kern = (bus_addr[21:6] == 16'o177723);
      hit_user = (bus_addr[21:6] == 16'o177776);
`ifdef MMU_SUPER_EN
      hit_super = (bus_addr[21:6] == 16'o177722);
`else
      hit_super = 1'b0;
`endif
      hit_mmr = 1'b1;
      mmr_idx = 2'd0;
      case (word_addr)
         22'o17777572: mmr_idx = 2'd0;
         22'o17777574: mmr_idx = 2'd1;
         22'o17777576: mmr_idx = 2'd2;
         22'o17772516: mmr_idx = 2'd3;
         default:      hit_mmr = 1'b0;
      endcase
      if (hit_user) begin
         mode = 2'b11;
      end else if (hit_super) begin
         mode = 2'b01;
      end else begin
         mode = 2'b00;
      end
      if (hit_mmr) begin
         map_addr = {2'b10, 4'b0000, mmr_idx};
      end else begin
         map_addr = {1'b0, bus_addr[5], mode, bus_addr[4], bus_addr[3:1]};
      end
      if (!bus_byte) begin
         map_be = 2'b11;
      end else if (bus_addr[0]) begin
         map_be = 2'b10;
      end else begin
         map_be = 2'b01;
      end
   end

   assign bus_decode = hit_kern | hit_super | hit_user | hit_mmr;

   always_comb begin
      state_d    = state_q;
      pxr_rd_d   = 1'b0;
      pxr_wr_d   = 1'b0;
      pxr_be_d   = pxr_be_q;
      pxr_addr_d = pxr_addr_q;
      pxr_data_d = pxr_data_q;
      rdata_d    = rdata_q;
      ack_d      = ack_q;
      case (state_q)
         StIdle: begin
            if (strobe && bus_decode) begin
               state_d    = StXfer;
               // Both strobes high resolves to a write.
               pxr_wr_d   = bus_wr;
               pxr_rd_d   = ~bus_wr;
               pxr_be_d   = map_be;
               pxr_addr_d = map_addr;
               pxr_data_d = bus_data_in;
            end
         end
         StXfer: begin
            // A master that withdrew mid-access gets no ack; the mmu access still happened.
            if (strobe) begin
               state_d = StAck;
               ack_d   = 1'b1;
               if (pxr_rd_q) begin
                  rdata_d = pxr_data_out;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StAck: begin
            if (!strobe) begin
               state_d = StIdle;
               ack_d   = 1'b0;
               rdata_d = 16'h0000;
            end
         end
         default: begin
            state_d = StIdle;
            ack_d   = 1'b0;
            rdata_d = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         pxr_rd_q   <= 1'b0;
         pxr_wr_q   <= 1'b0;
         pxr_be_q   <= 2'b00;
         pxr_addr_q <= 8'h00;
         pxr_data_q <= 16'h0000;
         rdata_q    <= 16'h0000;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pxr_rd_q   <= pxr_rd_d;
         pxr_wr_q   <= pxr_wr_d;
         pxr_be_q   <= pxr_be_d;
         pxr_addr_q <= pxr_addr_d;
         pxr_data_q <= pxr_data_d;
         rdata_q    <= rdata_d;
         ack_q      <= ack_d;
      end
   end

   assign pxr_rd       = pxr_rd_q;
   assign pxr_wr       = pxr_wr_q;
   assign pxr_be       = pxr_be_q;
   assign pxr_addr     = pxr_addr_q;
   assign pxr_data_in  = pxr_data_q;
   assign bus_data_out = rdata_q;
   assign bus_ack      = ack_q;

endmodule

// File: tb/tb_mmu_pxr_bridge.sv
// Directed bench for mmu_pxr_bridge: decode, strobe timing, byte enables, abort and reset cases.
// Runs the supervisor-group case both with and without MMU_SUPER_EN.
module tb_mmu_pxr_bridge;

   logic        clk;
   logic        reset_n;
   logic [21:0] bus_addr;
   logic        bus_rd;
   logic        bus_wr;
   logic        bus_byte;
   logic [15:0] bus_data_in;
   logic [15:0] bus_data_out;
   logic        bus_ack;
   logic        bus_decode;
   logic        pxr_rd;
   logic        pxr_wr;
   logic [1:0]  pxr_be;
   logic [7:0]  pxr_addr;
   logic [15:0] pxr_data_in;
   logic [15:0] pxr_data_out;

   int total;
   int bad;
   int rd_cnt;
   int wr_cnt;
   int both_cnt;
   int rd_mark;
   int wr_mark;

   mmu_pxr_bridge dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .bus_addr     (bus_addr),
      .bus_rd       (bus_rd),
      .bus_wr       (bus_wr),
      .bus_byte     (bus_byte),
      .bus_data_in  (bus_data_in),
      .bus_data_out (bus_data_out),
      .bus_ack      (bus_ack),
      .bus_decode   (bus_decode),
      .pxr_rd       (pxr_rd),
      .pxr_wr       (pxr_wr),
      .pxr_be       (pxr_be),
      .pxr_addr     (pxr_addr),
      .pxr_data_in  (pxr_data_in),
      .pxr_data_out (pxr_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (pxr_rd) rd_cnt <= rd_cnt + 1;
      if (pxr_wr) wr_cnt <= wr_cnt + 1;
      if (pxr_rd && pxr_wr) both_cnt <= both_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      reset_n = 1'b0;
      bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0; bus_byte = 1'b0;
      bus_data_in = '0; pxr_data_out = '0;
      tick();
      tick();
      check("reset_outputs", {bus_ack, pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_in, bus_data_out},
            64'h0);
      check("reset_nodecode", bus_decode, 1'b0);
      reset_n = 1'b1;
      tick();

      // 1: word write to kernel PAR0
      wr_mark = wr_cnt;
      bus_addr = 22'o17772340; bus_wr = 1'b1; bus_data_in = 16'o012345;
      #1;
      check("t1_decode", bus_decode, 1'b1);
      tick();
      check("t1_strobe", {pxr_rd, pxr_wr, bus_ack}, 3'b010);
      check("t1_addr", pxr_addr, 8'b0100_0000);
      check("t1_be", pxr_be, 2'b11);
      check("t1_wdata", pxr_data_in, 16'o012345);
      tick();
      check("t1_ack", {bus_ack, pxr_wr}, 2'b10);
      tick();
      tick();
      check("t1_ack_held", bus_ack, 1'b1);
      bus_wr = 1'b0;
      tick();
      check("t1_ack_drop", bus_ack, 1'b0);
      check("t1_one_wr", wr_cnt - wr_mark, 1);

      // 2: read MMR0
      rd_mark = rd_cnt;
      bus_addr = 22'o17777572; bus_rd = 1'b1; pxr_data_out = 16'o000001;
      tick();
      check("t2_strobe", {pxr_rd, pxr_wr}, 2'b10);
      check("t2_addr", pxr_addr, 8'b1000_0000);
      pxr_data_out = 16'o000001;
      tick();
      check("t2_ack", bus_ack, 1'b1);
      check("t2_rdata", bus_data_out, 16'o000001);
      pxr_data_out = 16'o000777;
      tick();
      check("t2_rdata_held", bus_data_out, 16'o000001);
      bus_rd = 1'b0;
      tick();
      check("t2_release", {bus_ack, bus_data_out}, 17'h0);
      check("t2_one_rd", rd_cnt - rd_mark, 1);

      // 3: byte write, high byte, user PAR1 (I space: addr[4]=0)
      bus_addr = 22'o17777643; bus_wr = 1'b1; bus_byte = 1'b1; bus_data_in = 16'o177400;
      tick();
      check("t3_addr", pxr_addr, 8'b0111_0001);
      check("t3_be", pxr_be, 2'b10);
      check("t3_wr", pxr_wr, 1'b1);
      tick();
      check("t3_ack", bus_ack, 1'b1);
      bus_wr = 1'b0;
      tick();

      // byte read, low byte, kernel PDR1: returns full word
      bus_addr = 22'o17772302; bus_rd = 1'b1; pxr_data_out = 16'o123456;
      tick();
      check("blo_addr", pxr_addr, 8'b0000_0001);
      check("blo_be", pxr_be, 2'b01);
      tick();
      check("blo_rdata", bus_data_out, 16'o123456);
      bus_rd = 1'b0; bus_byte = 1'b0;
      tick();

      // rd and wr together resolve to a write on MMR2
      bus_addr = 22'o17777576; bus_rd = 1'b1; bus_wr = 1'b1; bus_data_in = 16'o000017;
      tick();
      check("both_is_wr", {pxr_rd, pxr_wr}, 2'b01);
      check("both_addr", pxr_addr, 8'b1000_0010);
      tick();
      check("both_ack", bus_ack, 1'b1);
      check("both_rdata_zero", bus_data_out, 16'h0);
      bus_rd = 1'b0; bus_wr = 1'b0;
      tick();

      // 4: supervisor PDR0
      rd_mark = rd_cnt;
      bus_addr = 22'o17772200; bus_rd = 1'b1; pxr_data_out = 16'o000042;
      #1;
`ifdef MMU_SUPER_EN
      check("t4_decode", bus_decode, 1'b1);
      tick();
      check("t4_addr", pxr_addr, 8'b0001_0000);
      tick();
      check("t4_ack", bus_ack, 1'b1);
      bus_rd = 1'b0;
      tick();
      check("t4_one_rd", rd_cnt - rd_mark, 1);
`else
      check("t4_nodecode", bus_decode, 1'b0);
      for (int i = 0; i < 10; i++) tick();
      check("t4_noack", bus_ack, 1'b0);
      check("t4_no_rd", rd_cnt - rd_mark, 0);
      bus_rd = 1'b0;
      tick();
`endif

      // 5: read MMR3, strobe withdrawn during XFER
      rd_mark = rd_cnt;
      bus_addr = 22'o17772516; bus_rd = 1'b1;
      tick();
      check("t5_strobe", pxr_rd, 1'b1);
      check("t5_addr", pxr_addr, 8'b1000_0011);
      bus_rd = 1'b0;
      tick();
      check("t5_noack", {bus_ack, pxr_rd}, 2'b00);
      tick();
      tick();
      check("t5_noack_later", bus_ack, 1'b0);
      check("t5_one_rd", rd_cnt - rd_mark, 1);

      // 6: reset in ACK, then a clean repeat of test 1
      bus_addr = 22'o17772340; bus_wr = 1'b1; bus_data_in = 16'o012345;
      tick();
      tick();
      check("t6_in_ack", bus_ack, 1'b1);
      reset_n = 1'b0;
      #1;
      check("t6_async_reset",
            {bus_ack, pxr_rd, pxr_wr, pxr_be, pxr_addr, pxr_data_in, bus_data_out}, 64'h0);
      bus_wr = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      wr_mark = wr_cnt;
      bus_wr = 1'b1; bus_data_in = 16'o054321;
      tick();
      check("t6_strobe", {pxr_wr, bus_ack}, 2'b10);
      check("t6_wdata", pxr_data_in, 16'o054321);
      tick();
      check("t6_ack", bus_ack, 1'b1);
      bus_wr = 1'b0;
      tick();
      check("t6_release", bus_ack, 1'b0);
      check("t6_one_wr", wr_cnt - wr_mark, 1);

      // outside the map: no decode, no strobe
      wr_mark = wr_cnt;
      bus_addr = 22'o17772400; bus_wr = 1'b1;
      #1;
      check("nomap_decode", bus_decode, 1'b0);
      tick();
      tick();
      tick();
      check("nomap_noack", bus_ack, 1'b0);
      check("nomap_no_wr", wr_cnt - wr_mark, 0);
      bus_wr = 1'b0;
      tick();

      check("never_both", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
